// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver with start-glitch rejection, framing-error detection and a
// valid/ready hold register that flags overruns when downstream is still busy.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       data_ready,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   // state    | meaning
   // ST_IDLE  | line idle, waiting for a falling edge on rxs
   // ST_START | timing half a bit to re-check the start bit mid-cell
   // ST_DATA  | sampling 8 data bits, one per bit period, LSB first
   // ST_STOP  | waiting one bit period, then sampling the stop bit

   localparam int N  = CLKS_PER_BIT;
   localparam int H  = N / 2;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    idx, idx_nx;
   logic [7:0]    shift, shift_nx;
   logic          done_q, done_nx;
   logic          ferr_q, ferr_nx;
   logic          rx_meta, rxs;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         idx    <= '0;
         shift  <= '0;
         done_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         idx    <= idx_nx;
         shift  <= shift_nx;
         done_q <= done_nx;
         ferr_q <= ferr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      shift_nx = shift;
      done_nx  = 1'b0;
      ferr_nx  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rxs) begin
               cnt_nx   = '0;
               state_nx = ST_START;
            end
         end
         ST_START: begin
            if (cnt == CNT_HALF) begin
               if (!rxs) begin
                  state_nx = ST_DATA;
                  cnt_nx   = '0;
                  idx_nx   = '0;
               end else begin
                  state_nx = ST_IDLE;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt == CNT_LAST) begin
               shift_nx[idx] = rxs;
               cnt_nx        = '0;
               if (idx == 3'd7) begin
                  state_nx = ST_STOP;
               end else begin
                  idx_nx = idx + 3'd1;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         ST_STOP: begin
            // Return to idle mid-stop-bit so a back-to-back start edge is not missed.
            if (cnt == CNT_LAST) begin
               done_nx  = rxs;
               ferr_nx  = !rxs;
               cnt_nx   = '0;
               state_nx = ST_IDLE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data       <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= ferr_q;
         overrun   <= 1'b0;
         if (done_q) begin
            if (!data_valid || data_ready) begin
               data       <= shift;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: frame table plus hand-built corner sequences, with a
// scoreboard of expected output events (load / frame error / overrun) and their cycle.
module tb_uart_rx_byte;

   localparam int N = 16;
   localparam int H = N / 2;
   localparam int LAT = 3 + H + 9 * N;   // t0 to output update
   localparam int EV_LOAD = 0;
   localparam int EV_FE   = 1;
   localparam int EV_OVR  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       data_ready;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx_byte #(.CLKS_PER_BIT(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data_ready (data_ready),
      .data       (data),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int         kind;
      logic [7:0] val;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [7:0] b;
      logic       stop;
      logic       rdy;
      int         gap;
      int         kind;
      logic       exp_v;
      logic [7:0] exp_d;
   } vec_t;

   exp_t sbq[$];
   vec_t vecs[9];
   int   checks = 0;
   int   errors = 0;
   logic prev_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sb_check(input int k, input logic [7:0] v);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected: got event %0d data %0h at cycle %0d, expected no event",
                  k, v, cyc);
      end else begin
         e = sbq.pop_front();
         if (e.kind != k || e.cyc != cyc || (k == EV_LOAD && e.val !== v)) begin
            errors++;
            $display("FAIL sb_event: got kind %0d data %0h cycle %0d, expected kind %0d data %0h cycle %0d",
                     k, v, cyc, e.kind, e.val, e.cyc);
         end
      end
   endtask

   // Caller is at a negedge; returns at a negedge with the line idle.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit push, input int kind);
      exp_t e;
      rx = 1'b0;
      if (push) begin
         e.kind = kind;
         e.val  = b;
         e.cyc  = cyc + 1 + LAT;
         sbq.push_back(e);
      end
      repeat (N) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (N) @(negedge clk);
      end
      rx = stop;
      repeat (N) @(negedge clk);
      rx = 1'b1;
   endtask

   int nbusy;
   logic [7:0] mid_b;

   initial begin
      vecs[0] = '{8'h7A, 1'b0, 1'b0, 16, EV_FE,   1'b0, 8'h61};
      vecs[1] = '{8'h41, 1'b1, 1'b0,  0, EV_LOAD, 1'b1, 8'h41};
      vecs[2] = '{8'h42, 1'b1, 1'b0, 16, EV_OVR,  1'b1, 8'h41};
      vecs[3] = '{8'h41, 1'b1, 1'b1,  0, EV_LOAD, 1'b0, 8'h41};
      vecs[4] = '{8'h42, 1'b1, 1'b1, 16, EV_LOAD, 1'b0, 8'h42};
      vecs[5] = '{8'hA5, 1'b1, 1'b1, 16, EV_LOAD, 1'b0, 8'hA5};
      vecs[6] = '{8'h00, 1'b0, 1'b1, 16, EV_FE,   1'b0, 8'hA5};
      vecs[7] = '{8'hFF, 1'b1, 1'b0, 16, EV_LOAD, 1'b1, 8'hFF};
      vecs[8] = '{8'h3C, 1'b1, 1'b0, 16, EV_OVR,  1'b1, 8'hFF};

      rst = 1'b1;
      rx = 1'b0;
      data_ready = 1'b0;

      fork
         begin
            repeat (40000) @(posedge clk);
            $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
            $fatal(1, "watchdog expired");
         end
         forever begin
            @(negedge clk);
            if (data_valid && !prev_valid) sb_check(EV_LOAD, data);
            if (frame_err) sb_check(EV_FE, data);
            if (overrun) sb_check(EV_OVR, data);
            prev_valid = data_valid;
         end
      join_none

      // Reset with the line low; releasing with the line idle must not start a frame.
      repeat (3) @(negedge clk);
      chk("rst_data", data, 8'h00);
      chk("rst_valid", data_valid, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      rx = 1'b1;
      nbusy = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy) nbusy++;
      end
      chk("rst_no_frame_busy", nbusy, 0);

      // Single byte held until consumed.
      send_frame(8'h61, 1'b1, 1'b1, EV_LOAD);
      repeat (30) @(negedge clk);
      chk("single_valid_held", data_valid, 1'b1);
      chk("single_data", data, 8'h61);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      chk("consume_valid", data_valid, 1'b0);
      chk("consume_data", data, 8'h61);
      repeat (10) @(negedge clk);

      // Start glitch: 4 low cycles; busy for exactly the half-bit qualification window.
      rx = 1'b0;
      nbusy = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (i == 4) rx = 1'b1;
      end
      chk("glitch_busy_cycles", nbusy, H);
      chk("glitch_valid", data_valid, 1'b0);

      for (int i = 0; i < 9; i++) begin
         data_ready = vecs[i].rdy;
         send_frame(vecs[i].b, vecs[i].stop, 1'b1, vecs[i].kind);
         repeat (vecs[i].gap) @(negedge clk);
         chk($sformatf("vec%0d_valid", i), data_valid, vecs[i].exp_v);
         chk($sformatf("vec%0d_data", i), data, vecs[i].exp_d);
      end

      // Reset during data bit 3 of 0x55, then a clean frame.
      data_ready = 1'b0;
      repeat (10) @(negedge clk);
      mid_b = 8'h55;
      rx = 1'b0;
      repeat (N) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = mid_b[i];
         repeat (N) @(negedge clk);
      end
      rx = mid_b[3];
      repeat (H) @(negedge clk);
      rst = 1'b1;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("midrst_valid", data_valid, 1'b0);
      chk("midrst_data", data, 8'h00);
      nbusy = 0;
      repeat (200) begin
         @(negedge clk);
         if (busy) nbusy++;
      end
      chk("midrst_busy", nbusy, 0);
      send_frame(8'h30, 1'b1, 1'b1, EV_LOAD);
      repeat (20) @(negedge clk);
      chk("after_rst_valid", data_valid, 1'b1);
      chk("after_rst_data", data, 8'h30);

      repeat (20) @(negedge clk);
      chk("sb_empty", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
